fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Instruction-fetch controller for the MIPS core. Owns the program counter and drives the
//  combinational instruction memory (PC block: Adress -> Word). Sequences PC+4, branch/jump
//  redirects, decode back-pressure and halt/resume. Presents fetched words to decode via valid/ready.
// PARAMETERS
//  RESET_PC   32'h0  PC loaded on reset; must be word-aligned.
//  MEM_WORDS  64     instruction memory depth in words; PC wraps modulo MEM_WORDS*4 bytes.
// PORTS
//  clk             in   1   single clock, rising edge
//  rst_n           in   1   asynchronous active-low reset
//  imem_addr       out  32  byte address to instruction memory (Adress)
//  imem_word       in   32  instruction word returned combinationally (Word)
//  instr           out  32  registered instruction to decode
//  instr_pc        out  32  address that instr was fetched from
//  instr_valid     out  1   instr/instr_pc valid
//  instr_ready     in   1   decode accepts when instr_valid & instr_ready
//  redirect_valid  in   1   branch/jump taken this cycle
//  redirect_target in   32  new PC for a redirect
//  halt_req        in   1   level: stop issuing fetches
//  halted          out  1   high while in HALT
//  fetch_fault     out  1   misaligned redirect target (PC_ALIGN_CHECK_EN only; otherwise tied 0)
// BEHAVIOUR
//  Reset (async assert, sync release): pc=RESET_PC, imem_addr=RESET_PC, instr=0, instr_pc=0,
//   instr_valid=0, halted=0, fetch_fault=0, state=BOOT.
//  imem_addr = pc at all times (combinational from pc register).
//  Latency: 1 cycle; word at imem_addr in cycle N appears on instr, with instr_pc=pc, in cycle N+1.
//  FSM states: BOOT, RUN, STALL, HALT.
//   BOOT: one cycle after reset release; no capture; -> RUN (-> HALT if halt_req).
//   RUN: if output slot is empty or being accepted, capture imem_word, set instr_valid=1, pc<=next_pc.
//     If instr_valid & !instr_ready -> STALL; hold pc, instr, instr_pc.
//   STALL: hold everything; leave to RUN in the cycle instr_ready=1 (that cycle's capture proceeds).
//   HALT: no captures; pc held; halted=1; the pending instr stays valid until accepted;
//     halt_req=0 -> RUN the next cycle.
//  next_pc = (pc + 4) mod (MEM_WORDS*4); e.g. with MEM_WORDS=64, 252 -> 0.
//  Redirect: highest priority in every state except BOOT.
//   pc <= redirect_target mod (MEM_WORDS*4) on that edge; instr_valid <= 0 (wrong-path word flushed).
//   The state becomes RUN, or HALT if halt_req=1.
//   The first new-path word is valid 2 cycles after redirect_valid.
//  Priority: reset > redirect > halt_req > stall > sequential fetch.
//  Simultaneous accept + stall is impossible by construction: accept frees the slot the same cycle.
//  Reset mid-stall or mid-halt discards all state immediately (async).
//  Redirect target low 2 bits: ignored and forced to 0 unless PC_ALIGN_CHECK_EN.
// CONFIGURATION
//  PC_ALIGN_CHECK_EN defined:
//   Redirect with target[1:0]!=0 does not load pc. fetch_fault<=1 (sticky until reset), FSM -> HALT.
//   halted=1 and halt_req is ignored; only reset recovers.
//  Not defined: target[1:0] cleared, no fault, fetch_fault tied 0.
// TESTING
//  1 Reset, release, instr_ready=1, mem[i]=i*16 ->
//    imem_addr 0,4,8,12 on consecutive cycles; instr=0,16,32 with instr_pc=0,4,8, 1-cycle lag.
//  2 instr_ready=0 for 3 cycles at instr_pc=8 ->
//    instr/instr_pc/imem_addr frozen at 8/12; on release next instr_pc=12, no word lost or duplicated.
//  3 redirect_valid with target 128 while fetching 12 (MEM_WORDS=64 -> 128 legal) ->
//    instr_valid=0 for one cycle; then instr_pc=128; word at 16 never presented.
//  4 Sequential fetch from 248 -> instr_pc 248, 252, 0, 4 (wrap).
//  5 halt_req=1 for 4 cycles at pc=20 ->
//    halted=1, imem_addr stays 20, pending instr accepted once; release -> instr_pc=20 next.
//  6 With PC_ALIGN_CHECK_EN: redirect target 63 -> fetch_fault=1, halted=1, pc unchanged.
//    Without the macro: pc=60, fetch_fault=0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, drives the combinational imem, and
// hands registered words to decode over valid/ready. Optional macro: PC_ALIGN_CHECK_EN.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int          MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_word,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        halt_req,
  output logic        halted,
  output logic        fetch_fault
);

  localparam logic [31:0] PC_SPAN = 32'(MEM_WORDS * 4);

  typedef enum logic [1:0] {BOOT, RUN, STALL, HALT} state_t;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } slot_t;

  state_t      state, state_nxt;
  slot_t       slot, slot_nxt;
  logic [31:0] pc, pc_nxt, pc_seq, tgt;
  logic        vld, vld_nxt;
  logic        accept, slot_free;
  logic        tgt_bad, fault;

  assign accept    = vld & instr_ready;
  assign slot_free = ~vld | instr_ready;
  // pc is always aligned and below PC_SPAN, so pc+4 cannot overflow 32 bits
  assign pc_seq    = (pc + 32'd4 >= PC_SPAN) ? 32'd0 : pc + 32'd4;
  assign tgt       = (redirect_target & ~32'h3) % PC_SPAN;

`ifdef PC_ALIGN_CHECK_EN
  logic fault_nxt;
  assign tgt_bad = |redirect_target[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault <= 1'b0;
    else        fault <= fault_nxt;
  end
`else
  assign tgt_bad = 1'b0;
  assign fault   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
      pc    <= RESET_PC;
      slot  <= '0;
      vld   <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      slot  <= slot_nxt;
      vld   <= vld_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    slot_nxt  = slot;
    vld_nxt   = vld;
`ifdef PC_ALIGN_CHECK_EN
    fault_nxt = fault;
`endif
    // an accept always frees the slot; a capture below refills it
    if (accept) vld_nxt = 1'b0;
    case (state)
      BOOT: state_nxt = halt_req ? HALT : RUN;
      default: begin
        if (fault) begin
          state_nxt = HALT;
        end else if (redirect_valid) begin
          vld_nxt = 1'b0;
          if (tgt_bad) begin
`ifdef PC_ALIGN_CHECK_EN
            fault_nxt = 1'b1;
`endif
            state_nxt = HALT;
          end else begin
            pc_nxt    = tgt;
            state_nxt = halt_req ? HALT : RUN;
          end
        end else if (halt_req) begin
          state_nxt = HALT;
        end else if (state == HALT) begin
          state_nxt = RUN;
        end else if (slot_free) begin
          slot_nxt.word = imem_word;
          slot_nxt.pc   = pc;
          vld_nxt       = 1'b1;
          pc_nxt        = pc_seq;
          state_nxt     = RUN;
        end else begin
          state_nxt = STALL;
        end
      end
    endcase
  end

  assign imem_addr   = pc;
  assign instr       = slot.word;
  assign instr_pc    = slot.pc;
  assign instr_valid = vld;
  assign halted      = (state == HALT);
  assign fetch_fault = fault;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: one continuous vector table from reset,
// then hand-written sequences for async reset, BOOT redirect and redirect+halt in STALL.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr, imem_word, instr, instr_pc, redirect_target;
  logic        instr_valid, instr_ready, redirect_valid, halt_req, halted, fetch_fault;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // mem[i] = i*16, i.e. word at byte address a is a*4
  assign imem_word = imem_addr << 2;

  fetch_sequencer #(.RESET_PC(32'h0), .MEM_WORDS(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_word(imem_word),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .halt_req(halt_req), .halted(halted), .fetch_fault(fetch_fault)
  );

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] tgt;
    logic        hq;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_halt;
    logic        e_fault;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rdy, logic rv, logic [31:0] tgt, logic hq,
                              logic [31:0] a, logic v, logic [31:0] p, logic [31:0] w,
                              logic h, logic f);
    vec_t r;
    r.rdy = rdy; r.rv = rv; r.tgt = tgt; r.hq = hq;
    r.e_addr = a; r.e_vld = v; r.e_pc = p; r.e_instr = w; r.e_halt = h; r.e_fault = f;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] a, input logic v,
                         input logic [31:0] p, input logic [31:0] w, input logic h,
                         input logic f);
    chk({tag, ".imem_addr"}, imem_addr, a);
    chk({tag, ".instr_valid"}, 32'(instr_valid), 32'(v));
    chk({tag, ".instr_pc"}, instr_pc, p);
    chk({tag, ".instr"}, instr, w);
    chk({tag, ".halted"}, 32'(halted), 32'(h));
    chk({tag, ".fetch_fault"}, 32'(fetch_fault), 32'(f));
  endtask

  task automatic drive(input logic rdy, input logic rv, input logic [31:0] tgt, input logic hq);
    instr_ready = rdy; redirect_valid = rv; redirect_target = tgt; halt_req = hq;
  endtask

  initial begin
    // rows: inputs for the cycle, outputs expected during that cycle
    vecs.push_back(mk(1,0,0,0,    0,0,  0,   0,0,0)); // BOOT
    vecs.push_back(mk(1,0,0,0,    0,0,  0,   0,0,0));
    vecs.push_back(mk(1,0,0,0,    4,1,  0,   0,0,0));
    vecs.push_back(mk(1,0,0,0,    8,1,  4,  16,0,0));
    vecs.push_back(mk(0,0,0,0,   12,1,  8,  32,0,0)); // stall x3
    vecs.push_back(mk(0,0,0,0,   12,1,  8,  32,0,0));
    vecs.push_back(mk(0,0,0,0,   12,1,  8,  32,0,0));
    vecs.push_back(mk(1,0,0,0,   12,1,  8,  32,0,0));
    vecs.push_back(mk(1,1,128,0, 16,1, 12,  48,0,0)); // redirect 128
    vecs.push_back(mk(1,0,0,0,  128,0, 12,  48,0,0));
    vecs.push_back(mk(1,1,248,0,132,1,128, 512,0,0)); // redirect 248
    vecs.push_back(mk(1,0,0,0,  248,0,128, 512,0,0));
    vecs.push_back(mk(1,0,0,0,  252,1,248, 992,0,0));
    vecs.push_back(mk(1,0,0,0,    0,1,252,1008,0,0)); // wrap
    vecs.push_back(mk(1,0,0,0,    4,1,  0,   0,0,0));
    vecs.push_back(mk(1,1,16,0,   8,1,  4,  16,0,0)); // redirect 16
    vecs.push_back(mk(1,0,0,0,   16,0,  4,  16,0,0));
    vecs.push_back(mk(0,0,0,1,   20,1, 16,  64,0,0)); // halt x4
    vecs.push_back(mk(1,0,0,1,   20,1, 16,  64,1,0));
    vecs.push_back(mk(1,0,0,1,   20,0, 16,  64,1,0));
    vecs.push_back(mk(1,0,0,1,   20,0, 16,  64,1,0));
    vecs.push_back(mk(1,0,0,0,   20,0, 16,  64,1,0));
    vecs.push_back(mk(1,0,0,0,   20,0, 16,  64,0,0));
    vecs.push_back(mk(1,1,63,0,  24,1, 20,  80,0,0)); // misaligned redirect
`ifdef PC_ALIGN_CHECK_EN
    vecs.push_back(mk(1,0,0,0,   24,0, 20,  80,1,1));
    vecs.push_back(mk(0,0,0,1,   24,0, 20,  80,1,1));
    vecs.push_back(mk(0,0,0,0,   24,0, 20,  80,1,1));
`else
    vecs.push_back(mk(1,0,0,0,   60,0, 20,  80,0,0));
    vecs.push_back(mk(0,0,0,0,   64,1, 60, 240,0,0));
    vecs.push_back(mk(0,0,0,0,   64,1, 60, 240,0,0));
`endif

    rst_n = 1'b0;
    drive(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk_all("reset", 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      if (i == 0) rst_n = 1'b1;
      drive(vecs[i].rdy, vecs[i].rv, vecs[i].tgt, vecs[i].hq);
      chk_all($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_vld, vecs[i].e_pc,
              vecs[i].e_instr, vecs[i].e_halt, vecs[i].e_fault);
    end

    // async reset mid-stall/mid-halt: outputs clear without a clock edge
    #2 rst_n = 1'b0;
    #1 chk_all("async_rst", 0, 0, 0, 0, 0, 0);

    // redirect during BOOT is ignored
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 1, 100, 0);
    @(negedge clk);
    drive(1, 0, 0, 0);
    chk("boot_redirect.imem_addr", imem_addr, 0);
    @(negedge clk);
    drive(0, 0, 0, 0);
    chk_all("boot_fetch", 4, 1, 0, 0, 0, 0);
    // stalled, then redirect out-of-range target together with halt
    @(negedge clk);
    drive(0, 1, 300, 1);
    chk_all("stall_hold", 4, 1, 0, 0, 0, 0);
    @(negedge clk);
    drive(1, 0, 0, 0);
    chk_all("redir_halt", 44, 0, 0, 0, 1, 0);
    @(negedge clk);
    chk_all("resume", 44, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk_all("resume_fetch", 48, 1, 44, 176, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
